uart_prog_loader: RTL and testbench

Boot-time program loader upstream of the CPU core. It receives a framed program image over a UART RX line and writes it byte-by-byte into program RAM. When the image is accepted, it pulses the core's run input. It drives the RAM byte-write port while the core is halted or idle.

---
 rtl/uart_prog_loader_pkg.sv | 29 ++
 rtl/uart_prog_loader_rx.sv | 100 ++++++++++
 rtl/uart_prog_loader.sv | 174 +++++++++++++++++
 tb/tb_uart_prog_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader.
// Holds the framing FSM state codes, the receiver state codes and the
// frame header constant used by uart_prog_loader and uart_rx_byte.
// Optional feature macro: LOADER_CKSUM_EN (see uart_prog_loader.sv).
package uart_prog_loader_pkg;

   // Framing FSM states; S_CKS is only reachable with LOADER_CKSUM_EN
   typedef enum logic [2:0] {
      S_HDR,
      S_LENL,
      S_LENH,
      S_DATA,
      S_CKS,
      S_DONE,
      S_ERR
   } ldr_state_t;

   // Byte receiver states
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Every frame opens with this byte
   localparam logic [7:0] LDR_HDR = 8'hA5;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// uart_rx_byte: 8N1 UART byte receiver, LSB first.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   rxd      - asynchronous UART line, idle high
//   rx_valid - one-cycle strobe at the stop-bit sample, stop bit was 1
//   rx_byte  - received byte, stable while rx_valid is high
//   rx_ferr  - one-cycle strobe at the stop-bit sample, stop bit was 0
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_ferr
);
   import uart_prog_loader_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]    sync;
   logic          rx_s;
   logic          rx_prev;
   rx_state_t     state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    bit_idx, bit_idx_d;
   logic [7:0]    shift, shift_d;

   assign rx_s    = sync[1];
   assign rx_byte = shift;

   // Synchronizer and receiver registers; the synchronizer and the edge
   // history reset to the idle-high line level so reset never looks like
   // a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= 2'b11;
         rx_prev <= 1'b1;
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         sync    <= {sync[0], rxd};
         rx_prev <= rx_s;
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         shift   <= shift_d;
      end
   end

   // Receiver sequencing: a falling edge arms the start check, the start
   // bit is confirmed half a bit later (a short glitch reads high there and
   // is dropped), then each data bit and the stop bit are sampled one full
   // bit apart, i.e. at their centres
   always_comb begin
      state_d   = state;
      cnt_d     = cnt + 1'b1;
      bit_idx_d = bit_idx;
      shift_d   = shift;
      rx_valid  = 1'b0;
      rx_ferr   = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_d = '0;
            if (rx_prev && !rx_s) state_d = RX_START;
         end
         RX_START: begin
            if (cnt == HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == FULL) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift[7:1]};
               bit_idx_d = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == FULL) begin
               cnt_d    = '0;
               rx_valid = rx_s;
               rx_ferr  = !rx_s;
               state_d  = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: boot-time loader that receives a framed program image
// over UART and writes it byte by byte into program RAM, then pulses run.
// Frame: 0xA5, LEN_L, LEN_H, LEN data bytes, [CKSUM].
// Optional feature macro LOADER_CKSUM_EN: when defined a trailing CKSUM byte
// (8-bit sum of the data bytes) is received and checked; when undefined the
// frame ends after the last data byte and no accumulator exists.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   rxd     - UART receive line, idle high
//   wr_en   - one-cycle RAM byte-write strobe
//   wr_addr - RAM byte address for wr_en
//   wr_data - RAM byte data for wr_en
//   run     - one-cycle start pulse to the core
//   busy    - high from header accept until the frame completes or fails
//   err     - sticky error flag for the last frame
module uart_prog_loader #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rxd,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        run,
   output logic        busy,
   output logic        err
);
   import uart_prog_loader_pkg::*;

   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_ferr;

   ldr_state_t  state, state_d;
   logic [7:0]  len_lo, len_lo_d;
   logic [15:0] remaining, remaining_d;
   logic        wr_en_d, run_d, busy_d, err_d;
   logic [15:0] wr_addr_d;
   logic [7:0]  wr_data_d;
`ifdef LOADER_CKSUM_EN
   logic [7:0]  sum, sum_d;
`endif

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rxd      (rxd),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_ferr  (rx_ferr)
   );

   // State register plus registered outputs, so wr_en lands one cycle
   // after a data byte arrives and run one cycle after S_DONE is entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_HDR;
         len_lo    <= '0;
         remaining <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= BASE_ADDR;
         wr_data   <= '0;
         run       <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
`ifdef LOADER_CKSUM_EN
         sum       <= '0;
`endif
      end else begin
         state     <= state_d;
         len_lo    <= len_lo_d;
         remaining <= remaining_d;
         wr_en     <= wr_en_d;
         wr_addr   <= wr_addr_d;
         wr_data   <= wr_data_d;
         run       <= run_d;
         busy      <= busy_d;
         err       <= err_d;
`ifdef LOADER_CKSUM_EN
         sum       <= sum_d;
`endif
      end
   end

   // Framing FSM. The address steps in the cycle after each write strobe
   // and wraps naturally at 16 bits. A framing error anywhere inside a
   // frame aborts it; while hunting for a header, line noise is ignored
   always_comb begin
      state_d     = state;
      len_lo_d    = len_lo;
      remaining_d = remaining;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_en ? wr_addr + 16'd1 : wr_addr;
      wr_data_d   = wr_data;
      run_d       = 1'b0;
      busy_d      = busy;
      err_d       = err;
`ifdef LOADER_CKSUM_EN
      sum_d       = sum;
`endif
      case (state)
         S_HDR: begin
            if (rx_valid && rx_byte == LDR_HDR) begin
               state_d   = S_LENL;
               busy_d    = 1'b1;
               err_d     = 1'b0;
               wr_addr_d = BASE_ADDR;
`ifdef LOADER_CKSUM_EN
               sum_d     = '0;
`endif
            end
         end
         S_LENL: begin
            if (rx_ferr) state_d = S_ERR;
            else if (rx_valid) begin
               len_lo_d = rx_byte;
               state_d  = S_LENH;
            end
         end
         S_LENH: begin
            if (rx_ferr) state_d = S_ERR;
            else if (rx_valid) begin
               remaining_d = {rx_byte, len_lo};
               if ({rx_byte, len_lo} == 16'd0) begin
`ifdef LOADER_CKSUM_EN
                  state_d = S_CKS;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_ferr) state_d = S_ERR;
            else if (rx_valid) begin
               wr_en_d     = 1'b1;
               wr_data_d   = rx_byte;
               remaining_d = remaining - 16'd1;
`ifdef LOADER_CKSUM_EN
               sum_d       = sum + rx_byte;
               if (remaining == 16'd1) state_d = S_CKS;
`else
               if (remaining == 16'd1) state_d = S_DONE;
`endif
            end
         end
`ifdef LOADER_CKSUM_EN
         S_CKS: begin
            if (rx_ferr) state_d = S_ERR;
            else if (rx_valid) state_d = (rx_byte == sum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: begin
            run_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_HDR;
         end
         S_ERR: begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_HDR;
         end
         default: state_d = S_HDR;
      endcase
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader. Two instances are used: one at
// base address 0 and one at 16'hFFFE for the wrap-around case. Stimulus
// tasks push expected events into per-instance queues; a monitor on the
// falling clock edge pops and compares whenever a DUT writes, pulses run
// or raises err. Works with LOADER_CKSUM_EN defined or undefined.
module tb_uart_prog_loader;

   localparam int CPB = 16;

   typedef enum int {EV_WR, EV_RUN, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [15:0] addr;
      logic [7:0]  data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rxd0, rxd1;

   logic        wr_en0, wr_en1, run0, run1, busy0, busy1, err0, err1;
   logic [15:0] wr_addr0, wr_addr1;
   logic [7:0]  wr_data0, wr_data1;
   logic        busy_p0, busy_p1, err_p0, err_p1;

   exp_t q0[$];
   exp_t q1[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000)) dut0 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd0),
      .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
      .run(run0), .busy(busy0), .err(err0)
   );

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFE)) dut1 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd1),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .run(run1), .busy(busy1), .err(err1)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic pushExp(input int idx, input ev_kind_t k, input logic [15:0] a, input logic [7:0] d);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      if (idx == 0) q0.push_back(e);
      else          q1.push_back(e);
   endtask

   task automatic popExp(input int idx, input string name, output bit got, output exp_t e);
      got = 1'b0;
      e.kind = EV_WR;
      e.addr = '0;
      e.data = '0;
      if (idx == 0 && q0.size() != 0) begin
         e = q0.pop_front();
         got = 1'b1;
      end else if (idx == 1 && q1.size() != 0) begin
         e = q1.pop_front();
         got = 1'b1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("[TB] FAIL unexpected_%s dut%0d: got event required none at %0t", name, idx, $time);
      end
   endtask

   // Compare whatever one DUT presents this cycle against the queue head
   task automatic monitorDut(input int idx, input logic we, input logic [15:0] a, input logic [7:0] d,
                             input logic r, input logic b, input logic e, input logic bp, input logic ep);
      exp_t x;
      bit   got;
      if (we) begin
         popExp(idx, "write", got, x);
         if (got) begin
            checkOutput("wr_kind", 16'(EV_WR), 16'(x.kind));
            checkOutput("wr_addr", a, x.addr);
            checkOutput("wr_data", {8'h00, d}, {8'h00, x.data});
            checkOutput("wr_no_run", {15'b0, r}, 16'd0);
         end
      end
      if (r) begin
         popExp(idx, "run", got, x);
         if (got) begin
            checkOutput("run_kind", 16'(EV_RUN), 16'(x.kind));
            checkOutput("run_busy_low", {15'b0, b}, 16'd0);
            checkOutput("busy_before_run", {15'b0, bp}, 16'd1);
            checkOutput("run_err_low", {15'b0, e}, 16'd0);
         end
      end
      if (e && !ep) begin
         popExp(idx, "err", got, x);
         if (got) begin
            checkOutput("err_kind", 16'(EV_ERR), 16'(x.kind));
            checkOutput("err_busy_low", {15'b0, b}, 16'd0);
            checkOutput("err_no_run", {15'b0, r}, 16'd0);
         end
      end
   endtask

   // Event monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         monitorDut(0, wr_en0, wr_addr0, wr_data0, run0, busy0, err0, busy_p0, err_p0);
         monitorDut(1, wr_en1, wr_addr1, wr_data1, run1, busy1, err1, busy_p1, err_p1);
      end
      busy_p0 <= busy0;
      err_p0  <= err0;
      busy_p1 <= busy1;
      err_p1  <= err1;
   end

   task automatic setLine(input int idx, input logic v);
      if (idx == 0) rxd0 = v;
      else          rxd1 = v;
   endtask

   // One 8N1 character followed by two idle bit times
   task automatic applyStimulus(input int idx, input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         setLine(idx, bits[i]);
         repeat (CPB) @(negedge clk);
      end
      setLine(idx, 1'b1);
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic sendFrame(input int idx, input logic [7:0] fr[$]);
      foreach (fr[i]) applyStimulus(idx, fr[i], 1'b1);
   endtask

   // Bounded wait for all expected events, then check the idle flags
   task automatic finishFrame(input int idx, input string name, input logic exp_err);
      int left;
      for (int i = 0; i < 200; i++) begin
         left = (idx == 0) ? q0.size() : q1.size();
         if (left == 0) break;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      left = (idx == 0) ? q0.size() : q1.size();
      checkOutput({name, "_pending"}, 16'(left), 16'd0);
      checkOutput({name, "_busy"}, {15'b0, (idx == 0) ? busy0 : busy1}, 16'd0);
      checkOutput({name, "_err"}, {15'b0, (idx == 0) ? err0 : err1}, {15'b0, exp_err});
   endtask

   initial begin
      logic [7:0] fr[$];
      rst_n = 1'b0;
      rxd0  = 1'b1;
      rxd1  = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("rst_wr_en", {15'b0, wr_en0}, 16'd0);
      checkOutput("rst_wr_addr0", wr_addr0, 16'h0000);
      checkOutput("rst_wr_addr1", wr_addr1, 16'hFFFE);
      checkOutput("rst_wr_data", {8'h00, wr_data0}, 16'h0000);
      checkOutput("rst_run", {15'b0, run0}, 16'd0);
      checkOutput("rst_busy", {15'b0, busy0}, 16'd0);
      checkOutput("rst_err", {15'b0, err0}, 16'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Basic three-byte image
      pushExp(0, EV_WR, 16'h0000, 8'h11);
      pushExp(0, EV_WR, 16'h0001, 8'h22);
      pushExp(0, EV_WR, 16'h0002, 8'h33);
      pushExp(0, EV_RUN, 16'h0000, 8'h00);
`ifdef LOADER_CKSUM_EN
      fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
`else
      fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
`endif
      sendFrame(0, fr);
      finishFrame(0, "basic", 1'b0);

`ifdef LOADER_CKSUM_EN
      // Bad checksum, then a good frame clears err
      pushExp(0, EV_WR, 16'h0000, 8'h10);
      pushExp(0, EV_WR, 16'h0001, 8'h20);
      pushExp(0, EV_ERR, 16'h0000, 8'h00);
      fr = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h00};
      sendFrame(0, fr);
      finishFrame(0, "badcks", 1'b1);
      pushExp(0, EV_WR, 16'h0000, 8'h55);
      pushExp(0, EV_RUN, 16'h0000, 8'h00);
      fr = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'h55};
      sendFrame(0, fr);
      finishFrame(0, "recover", 1'b0);
`endif

      // Junk before header, zero-length image
      pushExp(0, EV_RUN, 16'h0000, 8'h00);
`ifdef LOADER_CKSUM_EN
      fr = '{8'h5A, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
`else
      fr = '{8'h5A, 8'h00, 8'hA5, 8'h00, 8'h00};
`endif
      sendFrame(0, fr);
      finishFrame(0, "zerolen", 1'b0);

      // Framing error on the second data byte
      pushExp(0, EV_WR, 16'h0000, 8'h11);
      pushExp(0, EV_ERR, 16'h0000, 8'h00);
      fr = '{8'hA5, 8'h03, 8'h00, 8'h11};
      sendFrame(0, fr);
      applyStimulus(0, 8'h22, 1'b0);
      finishFrame(0, "ferr", 1'b1);

      // Short low glitch between header and length must not become a byte
      pushExp(0, EV_WR, 16'h0000, 8'h7E);
      pushExp(0, EV_RUN, 16'h0000, 8'h00);
      applyStimulus(0, 8'hA5, 1'b1);
      rxd0 = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rxd0 = 1'b1;
      repeat (2 * CPB) @(negedge clk);
`ifdef LOADER_CKSUM_EN
      fr = '{8'h01, 8'h00, 8'h7E, 8'h7E};
`else
      fr = '{8'h01, 8'h00, 8'h7E};
`endif
      sendFrame(0, fr);
      finishFrame(0, "glitch", 1'b0);

      // Reset in the middle of the data phase
      pushExp(0, EV_WR, 16'h0000, 8'h01);
      pushExp(0, EV_WR, 16'h0001, 8'h02);
      fr = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02};
      sendFrame(0, fr);
      checkOutput("midframe_pending", 16'(q0.size()), 16'd0);
      checkOutput("midframe_busy", {15'b0, busy0}, 16'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_wr_en", {15'b0, wr_en0}, 16'd0);
      checkOutput("midrst_wr_addr", wr_addr0, 16'h0000);
      checkOutput("midrst_wr_data", {8'h00, wr_data0}, 16'h0000);
      checkOutput("midrst_run", {15'b0, run0}, 16'd0);
      checkOutput("midrst_busy", {15'b0, busy0}, 16'd0);
      checkOutput("midrst_err", {15'b0, err0}, 16'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      pushExp(0, EV_WR, 16'h0000, 8'hAA);
      pushExp(0, EV_WR, 16'h0001, 8'hBB);
      pushExp(0, EV_RUN, 16'h0000, 8'h00);
`ifdef LOADER_CKSUM_EN
      fr = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h65};
`else
      fr = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB};
`endif
      sendFrame(0, fr);
      finishFrame(0, "afterrst", 1'b0);

`ifndef LOADER_CKSUM_EN
      // Image with no checksum byte
      pushExp(0, EV_WR, 16'h0000, 8'h7E);
      pushExp(0, EV_RUN, 16'h0000, 8'h00);
      fr = '{8'hA5, 8'h01, 8'h00, 8'h7E};
      sendFrame(0, fr);
      finishFrame(0, "nocks", 1'b0);
`endif

      // Address wrap from a high base address
      pushExp(1, EV_WR, 16'hFFFE, 8'h01);
      pushExp(1, EV_WR, 16'hFFFF, 8'h02);
      pushExp(1, EV_WR, 16'h0000, 8'h03);
      pushExp(1, EV_WR, 16'h0001, 8'h04);
      pushExp(1, EV_RUN, 16'h0000, 8'h00);
`ifdef LOADER_CKSUM_EN
      fr = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
`else
      fr = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
      sendFrame(1, fr);
      finishFrame(1, "wrap", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
